// File: rtl/ntps_axil_pkg.sv
// Shared AXI-Lite definitions for the NTPS interface block: response codes,
// timeout-guard FSM states and the default read-timeout fill pattern.
package ntps_axil_pkg;

  localparam logic [1:0]  RESP_OKAY             = 2'b00;
  localparam logic [1:0]  RESP_SLVERR           = 2'b10;
  localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    WR_RESP,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } guard_state_e;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/axil_timeout_guard.sv
// Single-outstanding AXI-Lite pass-through that forces a SLVERR response when
// the downstream slave stays silent for TIMEOUT_CYCLES, and counts the fallout.
module axil_timeout_guard
  import ntps_axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA  = DATA_WIDTH'(DEFAULT_TIMEOUT_RDATA)
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,

  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]              s_axil_awprot,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]              s_axil_arprot,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,

  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready,

  output logic [15:0]             timeout_count,
  output logic [15:0]             late_count
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  guard_state_e state, state_d;

  logic [15:0]             timer;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
  logic [2:0]              aw_prot_q, ar_prot_q;
  logic [DATA_WIDTH-1:0]   w_data_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic [1:0]              bresp_q, rresp_q;
  logic                    aw_pend, w_pend, ar_pend;

  logic wr_take, rd_take;
  logic b_hs, r_hs;
  logic wr_active, rd_active;
  logic timer_last, wr_expire, rd_expire;
  logic aw_done, w_done;
  logic late_hit;

  assign wr_take    = s_axil_awvalid && s_axil_wvalid;
  assign rd_take    = s_axil_arvalid && !wr_take;
  assign b_hs       = m_axil_bvalid && m_axil_bready;
  assign r_hs       = m_axil_rvalid && m_axil_rready;
  assign wr_active  = (state == WR_ISSUE) || (state == WR_WAIT);
  assign rd_active  = (state == RD_ISSUE) || (state == RD_WAIT);
  assign timer_last = (timer == TIMER_LAST);
  assign wr_expire  = wr_active && timer_last && !b_hs;
  assign rd_expire  = rd_active && timer_last && !r_hs;
  assign aw_done    = !aw_pend || m_axil_awready;
  assign w_done     = !w_pend  || m_axil_wready;
  assign late_hit   = (state == IDLE) && (b_hs || r_hs);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (wr_take)      state_d = WR_ISSUE;
        else if (rd_take) state_d = RD_ISSUE;
      end
      WR_ISSUE: begin
        if (b_hs || wr_expire)   state_d = WR_RESP;
        else if (aw_done && w_done) state_d = WR_WAIT;
      end
      WR_WAIT:  if (b_hs || wr_expire) state_d = WR_RESP;
      WR_RESP:  if (s_axil_bready) state_d = IDLE;
      RD_ISSUE: begin
        if (r_hs || rd_expire)                 state_d = RD_RESP;
        else if (!ar_pend || m_axil_arready)   state_d = RD_WAIT;
      end
      RD_WAIT:  if (r_hs || rd_expire) state_d = RD_RESP;
      RD_RESP:  if (s_axil_rready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Readies are gated by the raw reset so they read 0 while reset is held,
  // even though IDLE (the reset state) would otherwise advertise them.
  always_comb begin
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_arready = 1'b0;
    s_axil_bvalid  = 1'b0;
    s_axil_rvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_rready  = 1'b0;
    if (axi_aresetn) begin
      case (state)
        IDLE: begin
          s_axil_awready = wr_take;
          s_axil_wready  = wr_take;
          s_axil_arready = rd_take;
          m_axil_bready  = 1'b1;
          m_axil_rready  = 1'b1;
        end
        WR_ISSUE, WR_WAIT: m_axil_bready = 1'b1;
        WR_RESP:           s_axil_bvalid = 1'b1;
        RD_ISSUE, RD_WAIT: m_axil_rready = 1'b1;
        RD_RESP:           s_axil_rvalid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      timer <= '0;
    end else begin
      timer <= (wr_active || rd_active) ? timer + 16'd1 : '0;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
      ar_prot_q <= '0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      ar_pend   <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_take) begin
            aw_addr_q <= s_axil_awaddr;
            aw_prot_q <= s_axil_awprot;
            w_data_q  <= s_axil_wdata;
            w_strb_q  <= s_axil_wstrb;
            aw_pend   <= 1'b1;
            w_pend    <= 1'b1;
          end else if (rd_take) begin
            ar_addr_q <= s_axil_araddr;
            ar_prot_q <= s_axil_arprot;
            ar_pend   <= 1'b1;
          end
        end
        WR_ISSUE, WR_WAIT: begin
          if (m_axil_awready) aw_pend <= 1'b0;
          if (m_axil_wready)  w_pend  <= 1'b0;
          if (b_hs) begin
            bresp_q <= m_axil_bresp;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
          end else if (wr_expire) begin
            bresp_q <= RESP_SLVERR;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
          end
        end
        RD_ISSUE, RD_WAIT: begin
          if (m_axil_arready) ar_pend <= 1'b0;
          if (r_hs) begin
            rdata_q <= m_axil_rdata;
            rresp_q <= m_axil_rresp;
            ar_pend <= 1'b0;
          end else if (rd_expire) begin
            rdata_q <= TIMEOUT_RDATA;
            rresp_q <= RESP_SLVERR;
            ar_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axil_awaddr  = aw_addr_q;
  assign m_axil_awprot  = aw_prot_q;
  assign m_axil_awvalid = aw_pend;
  assign m_axil_wdata   = w_data_q;
  assign m_axil_wstrb   = w_strb_q;
  assign m_axil_wvalid  = w_pend;
  assign m_axil_araddr  = ar_addr_q;
  assign m_axil_arprot  = ar_prot_q;
  assign m_axil_arvalid = ar_pend;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

  sat_counter16 u_timeout_cnt (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .inc   (wr_expire || rd_expire),
    .count (timeout_count)
  );

  sat_counter16 u_late_cnt (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .inc   (late_hit),
    .count (late_count)
  );

endmodule

// File: tb/tb_axil_timeout_guard.sv
// Directed bench for axil_timeout_guard with TIMEOUT_CYCLES = 16.
module tb_axil_timeout_guard;

  logic        axi_aclk;
  logic        axi_aresetn;
  logic [31:0] s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_awvalid, s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid, s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid, s_axil_bready;
  logic [31:0] s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid, s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid, s_axil_rready;
  logic [31:0] m_axil_awaddr;
  logic [2:0]  m_axil_awprot;
  logic        m_axil_awvalid, m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid, m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid, m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid, m_axil_rready;
  logic [15:0] timeout_count, late_count;

  axil_timeout_guard #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_RDATA  (32'hDEADBEEF)
  ) dut (
    .axi_aclk       (axi_aclk),
    .axi_aresetn    (axi_aresetn),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awprot  (s_axil_awprot),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arprot  (s_axil_arprot),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .m_axil_awaddr  (m_axil_awaddr),
    .m_axil_awprot  (m_axil_awprot),
    .m_axil_awvalid (m_axil_awvalid),
    .m_axil_awready (m_axil_awready),
    .m_axil_wdata   (m_axil_wdata),
    .m_axil_wstrb   (m_axil_wstrb),
    .m_axil_wvalid  (m_axil_wvalid),
    .m_axil_wready  (m_axil_wready),
    .m_axil_bresp   (m_axil_bresp),
    .m_axil_bvalid  (m_axil_bvalid),
    .m_axil_bready  (m_axil_bready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arprot  (m_axil_arprot),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready),
    .timeout_count  (timeout_count),
    .late_count     (late_count)
  );

  initial begin
    axi_aclk = 1'b0;
    forever #5 axi_aclk = ~axi_aclk;
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;       // write data, or slave rdata for reads
    logic [3:0]  strb;
    int          delay;      // cycle (0 = m_*valid rise) of slave response, -1 never
    logic [1:0]  sresp;
    int          bp;         // cycles of upstream backpressure
    int          late_after; // cycles in IDLE before a late response, -1 none
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [15:0] exp_tc;
    logic [15:0] exp_lc;
  } txn_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic run_txn(input txn_t t);
    int  k;
    bit  got;
    tick();
    if (t.wr) begin
      s_axil_awaddr = t.addr; s_axil_awprot = 3'b001; s_axil_awvalid = 1'b1;
      s_axil_wdata  = t.data; s_axil_wstrb  = t.strb; s_axil_wvalid  = 1'b1;
      #1 check("wr_accept_ready", {s_axil_awready, s_axil_wready}, 2'b11);
    end else begin
      s_axil_araddr = t.addr; s_axil_arprot = 3'b010; s_axil_arvalid = 1'b1;
      #1 check("rd_accept_ready", s_axil_arready, 1'b1);
    end
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    if (t.wr) begin
      check("m_aw_w_valid", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
      check("m_awaddr", m_axil_awaddr, t.addr);
      check("m_awprot", m_axil_awprot, 3'b001);
      check("m_wdata", m_axil_wdata, t.data);
      check("m_wstrb", m_axil_wstrb, t.strb);
    end else begin
      check("m_arvalid", m_axil_arvalid, 1'b1);
      check("m_araddr", m_axil_araddr, t.addr);
      check("m_arprot", m_axil_arprot, 3'b010);
    end
    k = 0;
    got = 1'b0;
    while (k < 64 && !got) begin
      if (k == t.delay) begin
        if (t.wr) begin m_axil_bvalid = 1'b1; m_axil_bresp = t.sresp; end
        else begin m_axil_rvalid = 1'b1; m_axil_rresp = t.sresp; m_axil_rdata = t.data; end
      end
      tick();
      m_axil_bvalid = 1'b0; m_axil_rvalid = 1'b0;
      k++;
      got = t.wr ? s_axil_bvalid : s_axil_rvalid;
    end
    check("resp_latency", k, t.exp_lat);
    if (t.wr) begin
      check("s_bresp", s_axil_bresp, t.exp_resp);
    end else begin
      check("s_rresp", s_axil_rresp, t.exp_resp);
      check("s_rdata", s_axil_rdata, t.exp_rdata);
    end
    check("m_valids_dropped", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 3'b000);
    check("timeout_count", timeout_count, t.exp_tc);
    for (int i = 0; i < t.bp; i++) begin
      tick();
      if (t.wr) check("bp_hold_b", {s_axil_bvalid, s_axil_bresp}, {1'b1, t.exp_resp});
      else check("bp_hold_r", {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, t.exp_resp, t.exp_rdata});
    end
    s_axil_bready = t.wr; s_axil_rready = !t.wr;
    tick();
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    check("resp_retired", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
    if (t.late_after >= 0) begin
      for (int i = 0; i < t.late_after; i++) tick();
      if (t.wr) m_axil_bvalid = 1'b1; else m_axil_rvalid = 1'b1;
      #1 check("drain_ready", {m_axil_bready, m_axil_rready}, 2'b11);
      tick();
      m_axil_bvalid = 1'b0; m_axil_rvalid = 1'b0;
      check("late_no_upstream", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
    end
    check("late_count", late_count, t.exp_lc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  txn_t vec[10];
  txn_t post;

  initial begin
    vec[0] = '{1'b1, 32'h10, 32'hA5A5A5A5, 4'hF,    3, 2'b00, 0, -1, 2'b00, 32'h0,        4,  16'd0, 16'd0};
    vec[1] = '{1'b0, 32'h20, 32'h0,        4'h0,   -1, 2'b00, 0, -1, 2'b10, 32'hDEADBEEF, 16, 16'd1, 16'd0};
    vec[2] = '{1'b0, 32'h20, 32'h0,        4'h0,   -1, 2'b00, 0,  5, 2'b10, 32'hDEADBEEF, 16, 16'd2, 16'd1};
    vec[3] = '{1'b1, 32'h30, 32'h11223344, 4'b0011, 15, 2'b00, 0, -1, 2'b00, 32'h0,        16, 16'd2, 16'd1};
    vec[4] = '{1'b0, 32'h40, 32'h12345678, 4'h0,    0, 2'b00, 0, -1, 2'b00, 32'h12345678, 1,  16'd2, 16'd1};
    vec[5] = '{1'b1, 32'h44, 32'h0BADCAFE, 4'b1100, 14, 2'b10, 0, -1, 2'b10, 32'h0,        15, 16'd2, 16'd1};
    vec[6] = '{1'b0, 32'h48, 32'hCAFEF00D, 4'h0,   15, 2'b10, 3, -1, 2'b10, 32'hCAFEF00D, 16, 16'd2, 16'd1};
    vec[7] = '{1'b1, 32'h4C, 32'h55AA55AA, 4'hF,   -1, 2'b00, 2, -1, 2'b10, 32'h0,        16, 16'd3, 16'd1};
    vec[8] = '{1'b1, 32'h50, 32'h00000001, 4'b0001, 0, 2'b00, 0, -1, 2'b00, 32'h0,        1,  16'd3, 16'd1};
    vec[9] = '{1'b1, 32'h54, 32'h87654321, 4'hF,   -1, 2'b00, 0,  2, 2'b10, 32'h0,        16, 16'd4, 16'd2};
    post   = '{1'b1, 32'h80, 32'h0F0F0F0F, 4'hF,    2, 2'b00, 0, -1, 2'b00, 32'h0,        3,  16'd0, 16'd0};

    axi_aresetn = 1'b0;
    s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0;  s_axil_wstrb = '0;  s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0;
    s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0;
    m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_arready = 1'b1;
    m_axil_bresp = '0; m_axil_bvalid = 1'b0;
    m_axil_rdata = '0; m_axil_rresp = '0; m_axil_rvalid = 1'b0;

    repeat (3) tick();
    check("rst_s_handshake", {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid}, 5'b0);
    check("rst_m_handshake", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready}, 5'b0);
    check("rst_resp_data", {s_axil_bresp, s_axil_rresp, s_axil_rdata}, 36'h0);
    check("rst_counters", {timeout_count, late_count}, 32'h0);
    axi_aresetn = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_txn(vec[i]);

    // Write/read tie: write goes first, read waits for the upstream B handshake.
    tick();
    s_axil_awaddr = 32'h60; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h6060_6060; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    s_axil_araddr = 32'h64; s_axil_arvalid = 1'b1;
    #1 check("tie_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b110);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    check("tie_write_first", {m_axil_awvalid, m_axil_arvalid}, 2'b10);
    check("tie_awaddr", m_axil_awaddr, 32'h60);
    tick();
    m_axil_bvalid = 1'b1; m_axil_bresp = 2'b01;
    tick();
    m_axil_bvalid = 1'b0;
    check("tie_bvalid", {s_axil_bvalid, s_axil_bresp, s_axil_arready}, {1'b1, 2'b01, 1'b0});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("tie_b_stable", {s_axil_bvalid, s_axil_bresp, m_axil_arvalid, s_axil_arready}, {1'b1, 2'b01, 1'b0, 1'b0});
    end
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
    check("tie_read_accept", {s_axil_bvalid, s_axil_arready}, 2'b01);
    tick();
    s_axil_arvalid = 1'b0;
    check("tie_read_issue", {m_axil_arvalid, m_axil_araddr}, {1'b1, 32'h64});
    m_axil_rvalid = 1'b1; m_axil_rdata = 32'h5A5A0001; m_axil_rresp = 2'b00;
    tick();
    m_axil_rvalid = 1'b0;
    check("tie_read_resp", {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, 2'b00, 32'h5A5A0001});
    s_axil_rready = 1'b1;
    tick();
    s_axil_rready = 1'b0;
    check("tie_counts", {timeout_count, late_count}, {16'd4, 16'd2});

    // Reset asserted while the read waits on a silent slave.
    s_axil_araddr = 32'h70; s_axil_arvalid = 1'b1;
    tick();
    s_axil_arvalid = 1'b0;
    tick();
    tick();
    check("pre_rst_wait", {s_axil_rvalid, m_axil_rready, m_axil_arvalid}, 3'b010);
    axi_aresetn = 1'b0;
    #1;
    check("async_rst_handshake", {m_axil_rready, m_axil_bready, m_axil_arvalid, s_axil_rvalid, s_axil_arready}, 5'b0);
    check("async_rst_counters", {timeout_count, late_count}, 32'h0);
    tick();
    tick();
    axi_aresetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_aborted_resp", {s_axil_rvalid, m_axil_arvalid}, 2'b00);
    end
    run_txn(post);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
